psum_collector: RTL and testbench

- Downstream stage of the glb_PE column array. Gathers one signed partial sum from each active PE column and adds them into a single output pixel.
- Emits that pixel on a valid/ready stream toward the output buffer, and marks the frame boundary on the last pixel.
- Runs in the PE array clock domain, on the same flush/kernel_size configuration plane as X_BusCtrl.

---
 rtl/psum_pkg.sv | 31 +++
 rtl/psum_adder_tree.sv | 28 ++
 rtl/psum_collector.sv | 222 ++++++++++++++++++++++
 tb/tb_psum_collector.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// psum_pkg: shared types, widths and arithmetic helpers for the partial-sum
// collector. sat_clamp is used only when PSUM_SAT_EN is defined.
package psum_pkg;

    localparam int PSUM_DW = 16;
    localparam int FRAME_W = 16;

    typedef logic signed [PSUM_DW-1:0] psum_t;

    // Output sum width: enough headroom for NUM_COL signed addends plus one guard bit.
    function automatic int psum_sum_w(input int dw, input int ncol);
        return dw + $clog2(ncol) + 1;
    endfunction

    // Clamp a sign-extended value to the signed range of a dw-bit word.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/psum_adder_tree.sv
// psum_adder_tree: combinational sum of NUM_COL signed words. Inputs whose
// enable bit is low contribute zero.
module psum_adder_tree
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 3,
    parameter int SUM_W      = psum_sum_w(DATA_WIDTH, NUM_COL)
) (
    input  logic [NUM_COL*DATA_WIDTH-1:0] in_flat,
    input  logic [NUM_COL-1:0]            en,
    output logic signed [SUM_W-1:0]       sum
);

    // Sign-extend each enabled column to SUM_W and accumulate.
    always_comb begin
        sum = {SUM_W{1'b0}};
        for (int i = 0; i < NUM_COL; i++) begin
            if (en[i]) begin
                sum = sum + $signed({{(SUM_W-DATA_WIDTH){in_flat[i*DATA_WIDTH+DATA_WIDTH-1]}},
                                     in_flat[i*DATA_WIDTH +: DATA_WIDTH]});
            end else begin
                sum = sum;
            end
        end
    end

endmodule

// File: rtl/psum_collector.sv
// psum_collector: gathers one signed partial sum per active PE column into
// one-deep hold registers, adds them once every active column is full, and
// presents the pixel on a valid/ready stream with a frame-end marker.
// Optional feature macro: PSUM_SAT_EN (saturate to DATA_WIDTH, adds sat_flag).
// Operating states are implied by the registers:
//   IDLE     : no hold full and out_valid low (busy=0)
//   COLLECT  : some hold full, out_valid low
//   HOLD_OUT : out_valid high
module psum_collector
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 3,
    parameter int SUM_W      = psum_sum_w(DATA_WIDTH, NUM_COL)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          cfg_load,
    input  logic [7:0]                    kernel_size,
    input  logic [FRAME_W-1:0]            frame_len,
    input  logic [NUM_COL*DATA_WIDTH-1:0] pe_psum,
    input  logic [NUM_COL-1:0]            pe_valid,
    output logic [NUM_COL-1:0]            pe_ready,
    output logic signed [SUM_W-1:0]       out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          busy,
    output logic                          err_cfg
`ifdef PSUM_SAT_EN
    ,
    output logic                          sat_flag
`endif
);

    localparam logic [7:0]         NCOL_B    = 8'(NUM_COL);
    localparam logic [FRAME_W-1:0] FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

    logic [NUM_COL*DATA_WIDTH-1:0] hold_d_q, hold_d_d;
    logic [NUM_COL-1:0]            hold_v_q, hold_v_d;
    logic                          out_valid_q, out_valid_d;
    logic signed [SUM_W-1:0]       out_data_q, out_data_d;
    logic                          out_last_q, out_last_d;
    logic                          err_cfg_q, err_cfg_d;
    logic [FRAME_W-1:0]            frame_cnt_q, frame_cnt_d;
    logic [FRAME_W-1:0]            frame_len_q, frame_len_d;
    logic [7:0]                    n_act_q, n_act_d;
`ifdef PSUM_SAT_EN
    logic                          sat_flag_q, sat_flag_d;
`endif

    logic [NUM_COL-1:0]            active_s;
    logic [NUM_COL-1:0]            pe_ready_s;
    logic [NUM_COL-1:0]            xfer_s;
    logic                          all_full_s;
    logic                          fire_s;
    logic                          busy_s;
    logic                          cfg_ok_s;
    logic                          last_hit_s;
    logic signed [SUM_W-1:0]       sum_s;
    logic signed [SUM_W-1:0]       sum_fin_s;
    logic                          sat_s;

    // Column activity, handshake and configuration-acceptance terms.
    always_comb begin
        for (int i = 0; i < NUM_COL; i++) begin
            active_s[i] = (8'(i) < n_act_q);
        end
        all_full_s = &(hold_v_q | ~active_s);
        fire_s     = all_full_s & (~out_valid_q | out_ready);
        for (int i = 0; i < NUM_COL; i++) begin
            pe_ready_s[i] = ~flush & (~active_s[i] | ~hold_v_q[i] | fire_s);
        end
        xfer_s     = pe_valid & pe_ready_s & active_s;
        busy_s     = (|hold_v_q) | out_valid_q;
        cfg_ok_s   = cfg_load & ~busy_s & ~(|(pe_valid & pe_ready_s));
        last_hit_s = (frame_len_q != {FRAME_W{1'b0}}) &&
                     (frame_cnt_q == (frame_len_q - FRAME_ONE));
    end

    psum_adder_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_COL    (NUM_COL),
        .SUM_W      (SUM_W)
    ) u_adder (
        .in_flat (hold_d_q),
        .en      (active_s),
        .sum     (sum_s)
    );

`ifdef PSUM_SAT_EN
    logic signed [63:0] sum_ext_s;
    logic signed [63:0] sat_v_s;

    // Clamp the full-precision sum to the DATA_WIDTH range and flag clamping.
    always_comb begin
        sum_ext_s = {{(64-SUM_W){sum_s[SUM_W-1]}}, sum_s};
        sat_v_s   = sat_clamp(sum_ext_s, DATA_WIDTH);
        sum_fin_s = sat_v_s[SUM_W-1:0];
        sat_s     = (sat_v_s != sum_ext_s);
    end
`else
    // Full-precision sum passes straight through.
    always_comb begin
        sum_fin_s = sum_s;
        sat_s     = 1'b0;
    end
`endif

    // Next-state logic: flush beats cfg_load, which beats the datapath.
    always_comb begin
        hold_d_d    = hold_d_q;
        hold_v_d    = hold_v_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        err_cfg_d   = err_cfg_q;
        frame_cnt_d = frame_cnt_q;
        frame_len_d = frame_len_q;
        n_act_d     = n_act_q;
`ifdef PSUM_SAT_EN
        sat_flag_d  = sat_flag_q;
`endif
        if (flush) begin
            hold_v_d    = {NUM_COL{1'b0}};
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            frame_cnt_d = {FRAME_W{1'b0}};
`ifdef PSUM_SAT_EN
            sat_flag_d  = 1'b0;
`endif
        end else if (cfg_ok_s) begin
            frame_len_d = frame_len;
            frame_cnt_d = {FRAME_W{1'b0}};
            if ((kernel_size == 8'd0) || (kernel_size > NCOL_B)) begin
                n_act_d   = NCOL_B;
                err_cfg_d = 1'b1;
            end else begin
                n_act_d   = kernel_size;
                err_cfg_d = 1'b0;
            end
        end else begin
            // A load that could not be accepted is reported, never applied.
            if (cfg_load) begin
                err_cfg_d = 1'b1;
            end else begin
                err_cfg_d = err_cfg_q;
            end
            for (int i = 0; i < NUM_COL; i++) begin
                if (xfer_s[i]) begin
                    hold_d_d[i*DATA_WIDTH +: DATA_WIDTH] = pe_psum[i*DATA_WIDTH +: DATA_WIDTH];
                    hold_v_d[i] = 1'b1;
                end else if (fire_s && active_s[i]) begin
                    hold_v_d[i] = 1'b0;
                end else begin
                    hold_v_d[i] = hold_v_q[i];
                end
            end
            if (fire_s) begin
                out_valid_d = 1'b1;
                out_data_d  = sum_fin_s;
                out_last_d  = last_hit_s;
                frame_cnt_d = last_hit_s ? {FRAME_W{1'b0}} : (frame_cnt_q + FRAME_ONE);
`ifdef PSUM_SAT_EN
                sat_flag_d  = sat_s;
`endif
            end else if (out_ready) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_d_q    <= {(NUM_COL*DATA_WIDTH){1'b0}};
            hold_v_q    <= {NUM_COL{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {SUM_W{1'b0}};
            out_last_q  <= 1'b0;
            err_cfg_q   <= 1'b0;
            frame_cnt_q <= {FRAME_W{1'b0}};
            frame_len_q <= {FRAME_W{1'b0}};
            n_act_q     <= NCOL_B;
`ifdef PSUM_SAT_EN
            sat_flag_q  <= 1'b0;
`endif
        end else begin
            hold_d_q    <= hold_d_d;
            hold_v_q    <= hold_v_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_cfg_q   <= err_cfg_d;
            frame_cnt_q <= frame_cnt_d;
            frame_len_q <= frame_len_d;
            n_act_q     <= n_act_d;
`ifdef PSUM_SAT_EN
            sat_flag_q  <= sat_flag_d;
`endif
        end
    end

    assign pe_ready  = pe_ready_s;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_s;
    assign err_cfg   = err_cfg_q;
`ifdef PSUM_SAT_EN
    assign sat_flag  = sat_flag_q;
`else
    // The clamp indicator only exists in the saturating build.
    logic unused_sat_s;
    assign unused_sat_s = sat_s;
`endif

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed stimulus with a scoreboard queue; a monitor pops
// and checks every accepted output pixel.
module tb_psum_collector;

    localparam int DW = 16;
    localparam int NC = 3;
    localparam int SW = DW + $clog2(NC) + 1;

    typedef struct {
        logic signed [SW-1:0] data;
        logic                 last;
        logic                 sat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 cfg_load;
    logic [7:0]           kernel_size;
    logic [15:0]          frame_len;
    logic [NC*DW-1:0]     pe_psum;
    logic [NC-1:0]        pe_valid;
    logic [NC-1:0]        pe_ready;
    logic signed [SW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 err_cfg;
`ifdef PSUM_SAT_EN
    logic                 sat_flag;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    psum_collector #(.DATA_WIDTH(DW), .NUM_COL(NC)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .cfg_load    (cfg_load),
        .kernel_size (kernel_size),
        .frame_len   (frame_len),
        .pe_psum     (pe_psum),
        .pe_valid    (pe_valid),
        .pe_ready    (pe_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .err_cfg     (err_cfg)
`ifdef PSUM_SAT_EN
        ,
        .sat_flag    (sat_flag)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_psum(input int a, input int b, input int c);
        pe_psum = {16'(c), 16'(b), 16'(a)};
    endtask

    task automatic push(input int v, input bit last, input bit sat);
        exp_t e;
        e.data = SW'(v);
        e.last = last;
        e.sat  = sat;
        sb.push_back(e);
    endtask

    task automatic do_cfg(input logic [7:0] ks, input logic [15:0] fl);
        cfg_load    = 1'b1;
        kernel_size = ks;
        frame_len   = fl;
        tick();
        cfg_load    = 1'b0;
    endtask

    // Monitor: compare every accepted output against the scoreboard head.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_last", {31'd0, out_last}, {31'd0, e.last});
`ifdef PSUM_SAT_EN
                check("sat_flag", {31'd0, sat_flag}, {31'd0, e.sat});
`endif
            end
        end
    end

    initial begin
        bit sat_en;
`ifdef PSUM_SAT_EN
        sat_en = 1'b1;
`else
        sat_en = 1'b0;
`endif
        rst = 1'b1; flush = 1'b0; cfg_load = 1'b0; kernel_size = 8'd0; frame_len = 16'd0;
        pe_psum = '0; pe_valid = 3'b000; out_ready = 1'b0;
        repeat (2) tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err_cfg", {31'd0, err_cfg}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_pe_ready", {29'd0, pe_ready}, 32'd7);

        // Aligned set, kernel 3, frame 4.
        do_cfg(8'd3, 16'd4);
        check("cfg3_err", {31'd0, err_cfg}, 32'd0);
        out_ready = 1'b1;
        set_psum(5, -2, 7); pe_valid = 3'b111; push(10, 1'b0, 1'b0);
        #1; check("aligned_ready0", {29'd0, pe_ready}, 32'd7);
        tick(); pe_valid = 3'b000;
        #1; check("aligned_ready1", {29'd0, pe_ready}, 32'd7);
        check("aligned_noval_yet", {31'd0, out_valid}, 32'd0);
        check("aligned_busy", {31'd0, busy}, 32'd1);
        tick();
        check("aligned_latency", {31'd0, out_valid}, 32'd1);
        tick();
        check("aligned_drained", {31'd0, busy}, 32'd0);

        // Skewed arrival: col0, col2, gap, col1.
        set_psum(1, 2, 3); pe_valid = 3'b001; tick();
        pe_valid = 3'b100; #1; check("skew_ready0_t1", {31'd0, pe_ready[0]}, 32'd0);
        tick();
        pe_valid = 3'b000; #1; check("skew_ready0_t2", {31'd0, pe_ready[0]}, 32'd0);
        tick();
        pe_valid = 3'b010; #1; check("skew_ready0_t3", {31'd0, pe_ready[0]}, 32'd0);
        push(6, 1'b0, 1'b0);
        tick(); pe_valid = 3'b000;
        check("skew_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        check("skew_out_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // Backpressure with a second set held behind the output.
        out_ready = 1'b0;
        set_psum(10, 20, 30); pe_valid = 3'b111; push(60, 1'b0, 1'b0);
        tick();
        set_psum(-1, -1, -1); push(-3, 1'b1, 1'b0);
        tick(); pe_valid = 3'b000;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready", {29'd0, pe_ready}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data", out_data, 32'd60);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_second_data", out_data, 32'hFFFF_FFFD);
        tick();

        // Back-to-back stream completing the first two frames.
        for (int k = 4; k < 8; k++) begin
            set_psum(k, 2 * k, -k); pe_valid = 3'b111; push(2 * k, (k == 7), 1'b0);
            #1; check("stream_ready", {29'd0, pe_ready}, 32'd7);
            tick();
        end
        pe_valid = 3'b000;
        repeat (3) tick();

        // kernel 2: column 2 ignored and always ready.
        do_cfg(8'd2, 16'd0);
        check("k2_err", {31'd0, err_cfg}, 32'd0);
        set_psum(100, 200, 999); pe_valid = 3'b111; push(300, 1'b0, 1'b0);
        tick();
        pe_valid = 3'b100; #1;
        check("k2_col2_ready", {31'd0, pe_ready[2]}, 32'd1);
        tick(); pe_valid = 3'b000;
        repeat (2) tick();

        // kernel 0: error, all columns used.
        do_cfg(8'd0, 16'd0);
        check("k0_err", {31'd0, err_cfg}, 32'd1);
        set_psum(1, 2, 3); pe_valid = 3'b111; push(6, 1'b0, 1'b0);
        tick(); pe_valid = 3'b000;
        repeat (2) tick();

        // cfg_load while busy is ignored and flagged.
        do_cfg(8'd3, 16'd0);
        check("k3_err_clear", {31'd0, err_cfg}, 32'd0);
        set_psum(4, 0, 0); pe_valid = 3'b001; tick();
        pe_valid = 3'b000;
        do_cfg(8'd1, 16'd0);
        check("busy_cfg_err", {31'd0, err_cfg}, 32'd1);
        set_psum(4, 5, 6); pe_valid = 3'b110; push(15, 1'b0, 1'b0);
        tick(); pe_valid = 3'b000;
        tick();
        check("busy_cfg_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // Flush with output pending and two holds full.
        do_cfg(8'd3, 16'd2);
        check("f_cfg_err", {31'd0, err_cfg}, 32'd0);
        out_ready = 1'b0;
        set_psum(1, 1, 1); pe_valid = 3'b111; tick();
        set_psum(7, 7, 7); pe_valid = 3'b011; tick();
        pe_valid = 3'b000;
        check("f_pre_busy", {31'd0, busy}, 32'd1);
        check("f_pre_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1; #1;
        check("f_ready_low", {29'd0, pe_ready}, 32'd0);
        tick(); flush = 1'b0;
        check("f_busy", {31'd0, busy}, 32'd0);
        check("f_valid", {31'd0, out_valid}, 32'd0);
        check("f_err_kept", {31'd0, err_cfg}, 32'd0);
        out_ready = 1'b1;
        set_psum(2, 3, 4); pe_valid = 3'b111; push(9, 1'b0, 1'b0); tick();
        set_psum(0, 0, 1); push(1, 1'b1, 1'b0); tick();
        pe_valid = 3'b000;
        repeat (2) tick();

        // Extremes: saturated in the clamping build, full precision otherwise.
        set_psum(32767, 32767, 1); pe_valid = 3'b111;
        push(sat_en ? 32767 : 65535, 1'b0, sat_en); tick();
        set_psum(-32768, -32768, 0);
        push(sat_en ? -32768 : -65536, 1'b1, sat_en); tick();
        pe_valid = 3'b000;
        repeat (3) tick();

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
